data_mem_interface: RTL and testbench
=====================================

DATA_MEM_INTERFACE -- requirements
Module: data_mem_interface

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  synchronous, active-high reset.
- REQ-003: address_from_cpu  input  64  CPU byte address.
- REQ-004: read_bit_from_cpu / write_bit_from_cpu  input  1 each  CPU load / store request, level-sensitive.
- REQ-005: size_select_from_cpu  input  2  access size: 11=doubleword (8B), 00=word (4B), 01=halfword (2B), 10=byte.
- REQ-006: write_data_from_cpu  input  64  store data, right-justified.
- REQ-007: DMBottom / DMTop  input  64 each  inclusive byte-address bounds of data memory.
- REQ-008: read_data_from_mem  input  64; read_ready_from_mem, write_ready_from_mem, write_finished_from_mem  input  1 each  memory handshakes.
- REQ-009: address_to_mem  output  64; size_select_to_mem  output  2; write_data_to_mem  output  64; read_request_to_mem, write_request_to_mem  output  1 each.
- REQ-010: read_data_to_cpu  output  64  last completed load result, zero-extended.

Function
- REQ-011: FSM states IDLE, WR_WAIT, WR_BUSY, RD_BUSY; all outputs registered.
- REQ-012: IDLE: write_bit_from_cpu=1 -> WR_WAIT; else read_bit_from_cpu=1 -> RD_BUSY; both high -> write wins; neither -> stay.
- REQ-013: On leaving IDLE, latch address_from_cpu, size_select_from_cpu and write_data_from_cpu; CPU inputs ignored until return to IDLE.
- REQ-014: address_to_mem = latched address (no translation); size_select_to_mem = latched size, unchanged encoding.
- REQ-015: write_data_to_mem = latched data masked to access size, upper bits zero (byte 0xFF, half 0xFFFF, word 0xFFFF_FFFF, dword all ones).
- REQ-016: WR_WAIT: write_request_to_mem=0; when write_ready_from_mem=1 assert write_request_to_mem next cycle -> WR_BUSY.
- REQ-017: WR_BUSY: hold write_request_to_mem=1 and stable address/data/size until write_finished_from_mem=1; then deassert -> IDLE.
- REQ-018: RD_BUSY: read_request_to_mem=1 until read_ready_from_mem=1; then capture read_data_from_mem masked to size, zero-extended, into read_data_to_cpu; deassert -> IDLE.
- REQ-019: read_data_to_cpu changes only on read completion or reset; holds value otherwise.
- REQ-020: Request bit still high on return to IDLE -> transaction re-issued with current CPU inputs (idempotent re-execution permitted).
- REQ-021: Interface overhead ≤2 clk cycles beyond memory handshake latency per transaction.
- REQ-022: Handshake inputs asserted in an unexpected state are ignored.

Reset
- REQ-023: rst=1 at a clock edge -> state IDLE, all outputs 0, latched registers 0, including mid-transaction (in-flight request dropped).
- REQ-024: rst has priority over all other inputs.

Configuration
- REQ-025: DMI_RANGE_CHECK_EN defined: access with address<DMBottom, address+size_bytes-1>DMTop, or address not size-aligned is not forwarded; a write is dropped, a read sets read_data_to_cpu=0; FSM returns to IDLE next cycle.
- REQ-026: DMI_RANGE_CHECK_EN undefined: DMBottom/DMTop ignored, every access forwarded regardless of alignment.

Verification
- REQ-027: Reset: rst=1 for 2 cycles mid-write -> all outputs 0, state IDLE, no request asserted.
- REQ-028: Store dword 0xDEADBEEFDEADBEEF @0x00, then load @0x00 size 11 -> read_data_to_cpu=0xDEADBEEFDEADBEEF.
- REQ-029: Store word 0xBADC0FEE @0x20, halfword 0xF00D @0x30, byte 0xAA @0x38; load each -> 0x00000000BADC0FEE, 0x000000000000F00D, 0x00000000000000AA (zero-extension).
- REQ-030: write_bit and read_bit high together @0x08 -> write handshake occurs first, read_request_to_mem stays 0 until write_finished_from_mem.
- REQ-031: Memory delays write_ready_from_mem 5 cycles -> write_request_to_mem stays 0 during delay, address/data stable throughout WR_BUSY.
- REQ-032: With DMI_RANGE_CHECK_EN, DMBottom=0, DMTop=0x3F: load @0x40 -> no read_request_to_mem, read_data_to_cpu=0; word store @0x22 -> no write_request_to_mem.

Source files
------------

// File: rtl/data_mem_interface.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_interface
// Purpose  : CPU-to-data-memory bridge; latches one load/store, runs the memory
//            handshake and returns size-masked, zero-extended load data.
//            Optional address range/alignment check: DMI_RANGE_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_interface (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] address_from_cpu,
    input  logic        read_bit_from_cpu,
    input  logic        write_bit_from_cpu,
    input  logic [1:0]  size_select_from_cpu,
    input  logic [63:0] write_data_from_cpu,
    input  logic [63:0] DMBottom,
    input  logic [63:0] DMTop,
    input  logic [63:0] read_data_from_mem,
    input  logic        read_ready_from_mem,
    input  logic        write_ready_from_mem,
    input  logic        write_finished_from_mem,
    output logic [63:0] address_to_mem,
    output logic [1:0]  size_select_to_mem,
    output logic [63:0] write_data_to_mem,
    output logic        read_request_to_mem,
    output logic        write_request_to_mem,
    output logic [63:0] read_data_to_cpu
);

    localparam logic [1:0] c_SZ_WORD  = 2'b00;
    localparam logic [1:0] c_SZ_HALF  = 2'b01;
    localparam logic [1:0] c_SZ_BYTE  = 2'b10;
    localparam logic [1:0] c_SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        WR_BUSY = 2'd2,
        RD_BUSY = 2'd3
    } state_t;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            c_SZ_BYTE:  size_mask = 64'h0000_0000_0000_00FF;
            c_SZ_HALF:  size_mask = 64'h0000_0000_0000_FFFF;
            c_SZ_WORD:  size_mask = 64'h0000_0000_FFFF_FFFF;
            c_SZ_DWORD: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            default:    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    state_t      r_state;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [63:0] r_wdata;
    logic        r_rd_req;
    logic        r_wr_req;
    logic [63:0] r_rdata;

    state_t      w_state_next;
    logic [63:0] w_addr_next;
    logic [1:0]  w_size_next;
    logic [63:0] w_wdata_next;
    logic        w_rd_req_next;
    logic        w_wr_req_next;
    logic [63:0] w_rdata_next;
    logic        w_access_ok;

`ifdef DMI_RANGE_CHECK_EN
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            c_SZ_BYTE:  size_bytes = 4'd1;
            c_SZ_HALF:  size_bytes = 4'd2;
            c_SZ_WORD:  size_bytes = 4'd4;
            default:    size_bytes = 4'd8;
        endcase
    endfunction

    logic [3:0]  w_nbytes;
    logic [2:0]  w_align_mask;
    logic [64:0] w_last_byte;

    assign w_nbytes     = size_bytes(size_select_from_cpu);
    assign w_align_mask = w_nbytes[2:0] - 3'd1;
    // 65-bit sum so an access wrapping past 2^64 is seen as out of range
    assign w_last_byte  = {1'b0, address_from_cpu} + {61'd0, w_nbytes} - 65'd1;
    assign w_access_ok  = (address_from_cpu >= DMBottom)
                        && (w_last_byte <= {1'b0, DMTop})
                        && ((address_from_cpu[2:0] & w_align_mask) == 3'd0);
`else
    logic w_unused_ok;

    assign w_unused_ok = ^{DMBottom, DMTop};
    assign w_access_ok = 1'b1;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_size_next   = r_size;
        w_wdata_next  = r_wdata;
        w_rd_req_next = r_rd_req;
        w_wr_req_next = r_wr_req;
        w_rdata_next  = r_rdata;

        case (r_state)
            IDLE: begin
                if (write_bit_from_cpu || read_bit_from_cpu) begin
                    if (w_access_ok) begin
                        w_addr_next  = address_from_cpu;
                        w_size_next  = size_select_from_cpu;
                        w_wdata_next = write_data_from_cpu & size_mask(size_select_from_cpu);
                        if (write_bit_from_cpu) begin
                            w_state_next = WR_WAIT;
                        end else begin
                            w_state_next  = RD_BUSY;
                            w_rd_req_next = 1'b1;
                        end
                    end else if (!write_bit_from_cpu) begin
                        // rejected load reports zero; rejected store is silently dropped
                        w_rdata_next = 64'd0;
                    end
                end
            end
            WR_WAIT: begin
                if (write_ready_from_mem) begin
                    w_state_next  = WR_BUSY;
                    w_wr_req_next = 1'b1;
                end
            end
            WR_BUSY: begin
                if (write_finished_from_mem) begin
                    w_state_next  = IDLE;
                    w_wr_req_next = 1'b0;
                end
            end
            RD_BUSY: begin
                if (read_ready_from_mem) begin
                    w_state_next  = IDLE;
                    w_rd_req_next = 1'b0;
                    w_rdata_next  = read_data_from_mem & size_mask(r_size);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= 64'd0;
            r_size   <= 2'd0;
            r_wdata  <= 64'd0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_rdata  <= 64'd0;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_size   <= w_size_next;
            r_wdata  <= w_wdata_next;
            r_rd_req <= w_rd_req_next;
            r_wr_req <= w_wr_req_next;
            r_rdata  <= w_rdata_next;
        end
    end

    assign address_to_mem       = r_addr;
    assign size_select_to_mem   = r_size;
    assign write_data_to_mem    = r_wdata;
    assign read_request_to_mem  = r_rd_req;
    assign write_request_to_mem = r_wr_req;
    assign read_data_to_cpu     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_interface
// Purpose  : directed self-checking bench with a byte-addressed memory model
//            and a load-result scoreboard for data_mem_interface.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_interface;

    logic        clk;
    logic        rst;
    logic [63:0] address_from_cpu;
    logic        read_bit_from_cpu;
    logic        write_bit_from_cpu;
    logic [1:0]  size_select_from_cpu;
    logic [63:0] write_data_from_cpu;
    logic [63:0] DMBottom;
    logic [63:0] DMTop;
    logic [63:0] read_data_from_mem;
    logic        read_ready_from_mem;
    logic        write_ready_from_mem;
    logic        write_finished_from_mem;
    logic [63:0] address_to_mem;
    logic [1:0]  size_select_to_mem;
    logic [63:0] write_data_to_mem;
    logic        read_request_to_mem;
    logic        write_request_to_mem;
    logic [63:0] read_data_to_cpu;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb[$];
    logic [63:0] last_rd  = 64'd0;
    logic [7:0]  mem [logic [63:0]];

    data_mem_interface dut (
        .clk                     (clk),
        .rst                     (rst),
        .address_from_cpu        (address_from_cpu),
        .read_bit_from_cpu       (read_bit_from_cpu),
        .write_bit_from_cpu      (write_bit_from_cpu),
        .size_select_from_cpu    (size_select_from_cpu),
        .write_data_from_cpu     (write_data_from_cpu),
        .DMBottom                (DMBottom),
        .DMTop                   (DMTop),
        .read_data_from_mem      (read_data_from_mem),
        .read_ready_from_mem     (read_ready_from_mem),
        .write_ready_from_mem    (write_ready_from_mem),
        .write_finished_from_mem (write_finished_from_mem),
        .address_to_mem          (address_to_mem),
        .size_select_to_mem      (size_select_to_mem),
        .write_data_to_mem       (write_data_to_mem),
        .read_request_to_mem     (read_request_to_mem),
        .write_request_to_mem    (write_request_to_mem),
        .read_data_to_cpu        (read_data_to_cpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b10:   return 1;
            2'b01:   return 2;
            2'b00:   return 4;
            default: return 8;
        endcase
    endfunction

    // Unwritten bytes read back as 0x5A so missing load masking is visible
    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] ba;
            ba = a + 64'(i);
            v[8*i +: 8] = mem.exists(ba) ? mem[ba] : 8'h5A;
        end
        return v;
    endfunction

    task automatic mem_commit();
        for (int i = 0; i < nbytes(size_select_to_mem); i++)
            mem[address_to_mem + 64'(i)] = write_data_to_mem[8*i +: 8];
    endtask

    task automatic do_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d,
                            input logic [63:0] exp_d, input int ready_delay);
        address_from_cpu     = a;
        size_select_from_cpu = sz;
        write_data_from_cpu  = d;
        write_bit_from_cpu   = 1'b1;
        @(negedge clk);
        write_bit_from_cpu   = 1'b0;
        address_from_cpu     = ~a;
        write_data_from_cpu  = ~d;
        size_select_from_cpu = ~sz;
        chk("wr_wait_req", 64'(write_request_to_mem), 64'd0);
        chk("wr_addr", address_to_mem, a);
        chk("wr_data", write_data_to_mem, exp_d);
        chk("wr_size", 64'(size_select_to_mem), 64'(sz));
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            chk("wr_wait_hold", 64'(write_request_to_mem), 64'd0);
        end
        write_ready_from_mem = 1'b1;
        @(negedge clk);
        write_ready_from_mem = 1'b0;
        chk("wr_req_on", 64'(write_request_to_mem), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("wr_busy_req", 64'(write_request_to_mem), 64'd1);
            chk("wr_busy_addr", address_to_mem, a);
            chk("wr_busy_data", write_data_to_mem, exp_d);
            chk("wr_busy_rdreq", 64'(read_request_to_mem), 64'd0);
        end
        mem_commit();
        write_finished_from_mem = 1'b1;
        @(negedge clk);
        write_finished_from_mem = 1'b0;
        chk("wr_req_off", 64'(write_request_to_mem), 64'd0);
        chk("wr_done_rdreq", 64'(read_request_to_mem), 64'd0);
    endtask

    task automatic do_load(input logic [63:0] a, input logic [1:0] sz,
                           input logic [63:0] exp, input int delay);
        logic [63:0] e;
        address_from_cpu     = a;
        size_select_from_cpu = sz;
        read_bit_from_cpu    = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        read_bit_from_cpu    = 1'b0;
        address_from_cpu     = ~a;
        size_select_from_cpu = ~sz;
        chk("rd_req_on", 64'(read_request_to_mem), 64'd1);
        chk("rd_addr", address_to_mem, a);
        chk("rd_size", 64'(size_select_to_mem), 64'(sz));
        chk("rd_wrreq", 64'(write_request_to_mem), 64'd0);
        chk("rd_hold", read_data_to_cpu, last_rd);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("rd_busy_req", 64'(read_request_to_mem), 64'd1);
        end
        read_data_from_mem  = mem_rd(address_to_mem);
        read_ready_from_mem = 1'b1;
        @(negedge clk);
        read_ready_from_mem = 1'b0;
        read_data_from_mem  = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("rd_req_off", 64'(read_request_to_mem), 64'd0);
        e = sb.pop_front();
        chk("rd_data", read_data_to_cpu, e);
        last_rd = e;
    endtask

    initial begin
        rst                     = 1'b1;
        address_from_cpu        = 64'd0;
        read_bit_from_cpu       = 1'b0;
        write_bit_from_cpu      = 1'b0;
        size_select_from_cpu    = 2'b00;
        write_data_from_cpu     = 64'd0;
        DMBottom                = 64'h0;
        DMTop                   = 64'h3F;
        read_data_from_mem      = 64'd0;
        read_ready_from_mem     = 1'b0;
        write_ready_from_mem    = 1'b0;
        write_finished_from_mem = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_addr", address_to_mem, 64'd0);
        chk("rst_rdreq", 64'(read_request_to_mem), 64'd0);
        chk("rst_wrreq", 64'(write_request_to_mem), 64'd0);
        chk("rst_rdata", read_data_to_cpu, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Doubleword round trip
        do_store(64'h00, 2'b11, 64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        do_load (64'h00, 2'b11, 64'hDEAD_BEEF_DEAD_BEEF, 1);

        // Narrow stores carry junk in the upper bits; loads must zero-extend
        do_store(64'h20, 2'b00, 64'h1234_5678_BADC_0FEE, 64'h0000_0000_BADC_0FEE, 0);
        do_store(64'h30, 2'b01, 64'h9999_8888_7777_F00D, 64'h0000_0000_0000_F00D, 1);
        do_store(64'h38, 2'b10, 64'h5555_4444_3333_22AA, 64'h0000_0000_0000_00AA, 0);
        do_load (64'h20, 2'b00, 64'h0000_0000_BADC_0FEE, 0);
        do_load (64'h30, 2'b01, 64'h0000_0000_0000_F00D, 2);
        do_load (64'h38, 2'b10, 64'h0000_0000_0000_00AA, 0);

        // Simultaneous write and read: write first, read follows
        read_bit_from_cpu = 1'b1;
        do_store(64'h08, 2'b11, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0);
        do_load (64'h08, 2'b11, 64'h1111_2222_3333_4444, 0);

        // Slow write_ready
        do_store(64'h18, 2'b11, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 5);
        do_load (64'h18, 2'b11, 64'h0123_4567_89AB_CDEF, 0);

        // Reset in the middle of a write
        address_from_cpu     = 64'h10;
        size_select_from_cpu = 2'b00;
        write_data_from_cpu  = 64'hCAFE_F00D_1234_5678;
        write_bit_from_cpu   = 1'b1;
        @(negedge clk);
        write_bit_from_cpu   = 1'b0;
        write_ready_from_mem = 1'b1;
        @(negedge clk);
        write_ready_from_mem = 1'b0;
        chk("mid_wr_req", 64'(write_request_to_mem), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst2_addr", address_to_mem, 64'd0);
        chk("rst2_size", 64'(size_select_to_mem), 64'd0);
        chk("rst2_wdata", write_data_to_mem, 64'd0);
        chk("rst2_rdreq", 64'(read_request_to_mem), 64'd0);
        chk("rst2_wrreq", 64'(write_request_to_mem), 64'd0);
        chk("rst2_rdata", read_data_to_cpu, 64'd0);
        rst = 1'b0;
        last_rd = 64'd0;
        // Stray handshakes while idle are ignored
        write_finished_from_mem = 1'b1;
        read_ready_from_mem     = 1'b1;
        read_data_from_mem      = 64'h7777_7777_7777_7777;
        @(negedge clk);
        write_finished_from_mem = 1'b0;
        read_ready_from_mem     = 1'b0;
        chk("idle_wrreq", 64'(write_request_to_mem), 64'd0);
        chk("idle_rdreq", 64'(read_request_to_mem), 64'd0);
        chk("idle_rdata", read_data_to_cpu, 64'd0);
        do_load(64'h20, 2'b00, 64'h0000_0000_BADC_0FEE, 0);

`ifdef DMI_RANGE_CHECK_EN
        // Out-of-range load reports zero, no request
        address_from_cpu     = 64'h40;
        size_select_from_cpu = 2'b11;
        read_bit_from_cpu    = 1'b1;
        @(negedge clk);
        read_bit_from_cpu    = 1'b0;
        chk("rng_rdreq", 64'(read_request_to_mem), 64'd0);
        chk("rng_rdata", read_data_to_cpu, 64'd0);
        last_rd = 64'd0;
        // Misaligned word store is dropped
        address_from_cpu     = 64'h22;
        size_select_from_cpu = 2'b00;
        write_data_from_cpu  = 64'h0000_0000_1357_9BDF;
        write_bit_from_cpu   = 1'b1;
        @(negedge clk);
        write_bit_from_cpu   = 1'b0;
        write_ready_from_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rng_wrreq", 64'(write_request_to_mem), 64'd0);
        end
        write_ready_from_mem = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
